// File: rtl/fuse_issue_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// fuse_issue_ctrl_pkg : shared state encoding and width helper
// Rev 1.0
//------------------------------------------------------------------
package fuse_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    FIC_RUN    = 2'd0,
    FIC_FLUSH  = 2'd1,
    FIC_RESUME = 2'd2
  } fic_state_e;

  // Bits needed to hold a credit count in the range 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fuse_issue_ctrl_popcount_n.sv
`default_nettype none
//------------------------------------------------------------------
// popcount_n : parameterised N-bit population count
// Rev 1.0
//------------------------------------------------------------------
module popcount_n #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + W'(i_bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fuse_issue_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// fuse_issue_ctrl : credit flow and flush sequencer, fuse -> rename
// Rev 1.0
//------------------------------------------------------------------
module fuse_issue_ctrl
  import fuse_issue_ctrl_pkg::*;
#(
  parameter int NUM_UOPS_OUT = 4,
  parameter int CREDITS      = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             IN_mispredict,
  input  logic                             IN_fuseFull,
  input  logic [NUM_UOPS_OUT-1:0]          IN_fuseOutValid,
  input  logic [credit_width(CREDITS)-1:0] IN_creditRet,
  output logic                             OUT_fuseOutEn,
  output logic                             OUT_fuseMispredict,
  output logic                             OUT_decStall,
  output logic [credit_width(CREDITS)-1:0] OUT_credits,
  output logic [31:0]                      OUT_stallCnt
);

  localparam int c_cw = credit_width(CREDITS);
  localparam int c_sw = c_cw + 2;
  localparam int c_pw = $clog2(NUM_UOPS_OUT + 1);
  localparam int c_fw = $clog2(FLUSH_CYCLES + 1);
  localparam logic [c_fw-1:0] c_flush_reload = c_fw'(FLUSH_CYCLES - 1);
  localparam logic [c_cw-1:0] c_credits_max  = c_cw'(CREDITS);
  localparam logic [c_cw-1:0] c_slot_cost    = c_cw'(NUM_UOPS_OUT);

  fic_state_e       r_state, w_state_nxt;
  logic [c_fw-1:0]  r_flush_cnt, w_flush_cnt_nxt;
  logic [c_cw-1:0]  r_credits, w_credits_nxt;
  logic             r_pending;
  logic [31:0]      r_stall_cnt;
  logic [c_pw-1:0]  w_valid_cnt;
  logic [c_sw-1:0]  w_debit, w_refund, w_sum;

  popcount_n #(.N(NUM_UOPS_OUT), .W(c_pw)) u_popcount (
    .i_bits  (IN_fuseOutValid),
    .o_count (w_valid_cnt)
  );

  assign OUT_fuseOutEn      = (r_state == FIC_RUN) && !IN_mispredict && (r_credits >= c_slot_cost);
  assign OUT_fuseMispredict = IN_mispredict || (r_state == FIC_FLUSH);
  assign OUT_decStall       = IN_fuseFull || (r_state != FIC_RUN) || IN_mispredict;
  assign OUT_credits        = r_credits;
  assign OUT_stallCnt       = r_stall_cnt;

  always_comb begin
    // Slots reserved last cycle but left empty by the fuse come back here.
    w_debit  = OUT_fuseOutEn ? c_sw'(NUM_UOPS_OUT) : '0;
    w_refund = r_pending ? (c_sw'(NUM_UOPS_OUT) - c_sw'(w_valid_cnt)) : '0;
    w_sum    = c_sw'(r_credits) - w_debit + w_refund + c_sw'(IN_creditRet);

    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_credits_nxt   = r_credits;

    if (IN_mispredict) begin
      w_state_nxt     = FIC_FLUSH;
      w_flush_cnt_nxt = c_flush_reload;
    end else begin
      case (r_state)
        FIC_RUN: begin
          w_credits_nxt = (w_sum > c_sw'(CREDITS)) ? c_credits_max : w_sum[c_cw-1:0];
        end
        FIC_FLUSH: begin
          if (r_flush_cnt == '0) begin
            w_state_nxt = FIC_RESUME;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - c_fw'(1);
          end
        end
        FIC_RESUME: begin
          w_credits_nxt = c_credits_max;
          w_state_nxt   = FIC_RUN;
        end
        default: begin
          w_state_nxt = FIC_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FIC_RUN;
      r_flush_cnt <= '0;
      r_credits   <= c_credits_max;
      r_pending   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_credits   <= w_credits_nxt;
      // outEn is never high outside RUN or with a mispredict, so this also clears pending.
      r_pending   <= OUT_fuseOutEn;
      if (OUT_decStall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  a_credits_bounded: assert property (@(posedge clk) disable iff (!rst)
    r_credits <= c_credits_max);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    OUT_fuseOutEn |-> (r_credits >= c_slot_cost));
  a_pending_in_run: assert property (@(posedge clk) disable iff (!rst)
    r_pending |-> (r_state == FIC_RUN));

endmodule
`default_nettype wire

// File: tb/tb_fuse_issue_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// tb_fuse_issue_ctrl : scoreboard bench for fuse_issue_ctrl
// Rev 1.0
//------------------------------------------------------------------
module tb_fuse_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_mispredict = 1'b0;
  logic        IN_fuseFull = 1'b0;
  logic [3:0]  IN_fuseOutValid = 4'h0;
  logic [4:0]  IN_creditRet = 5'd0;
  logic        OUT_fuseOutEn;
  logic        OUT_fuseMispredict;
  logic        OUT_decStall;
  logic [4:0]  OUT_credits;
  logic [31:0] OUT_stallCnt;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       mp;
    logic       full;
    logic [3:0] valid;
    logic [4:0] ret;
  } stim_t;

  typedef struct packed {
    logic       en;
    logic       mpo;
    logic       stall;
    logic [4:0] cred;
  } exp_t;

  exp_t sb[$];

  fuse_issue_ctrl #(.NUM_UOPS_OUT(4), .CREDITS(16), .FLUSH_CYCLES(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .IN_mispredict      (IN_mispredict),
    .IN_fuseFull        (IN_fuseFull),
    .IN_fuseOutValid    (IN_fuseOutValid),
    .IN_creditRet       (IN_creditRet),
    .OUT_fuseOutEn      (OUT_fuseOutEn),
    .OUT_fuseMispredict (OUT_fuseMispredict),
    .OUT_decStall       (OUT_decStall),
    .OUT_credits        (OUT_credits),
    .OUT_stallCnt       (OUT_stallCnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 rst = 1'b0;
    IN_fuseFull = 1'b1;
    #2;
    total++; if (OUT_fuseOutEn !== 1'b1) begin bad++; $display("FAIL reset outEn got=%b want=1", OUT_fuseOutEn); end
    total++; if (OUT_fuseMispredict !== 1'b0) begin bad++; $display("FAIL reset fuseMispredict got=%b want=0", OUT_fuseMispredict); end
    total++; if (OUT_decStall !== 1'b1) begin bad++; $display("FAIL reset decStall(full=1) got=%b want=1", OUT_decStall); end
    total++; if (OUT_credits !== 5'd16) begin bad++; $display("FAIL reset credits got=%0d want=16", OUT_credits); end
    total++; if (OUT_stallCnt !== 32'd0) begin bad++; $display("FAIL reset stallCnt got=%0d want=0", OUT_stallCnt); end
    IN_fuseFull = 1'b0;
    #1;
    total++; if (OUT_decStall !== 1'b0) begin bad++; $display("FAIL reset decStall(full=0) got=%b want=0", OUT_decStall); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Drives one table row per cycle, pushes its expectation, pops and checks before the next edge.
  task automatic test_drain();
    stim_t st [6] = '{'{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0},
                      '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}};
    exp_t  ex [6] = '{'{1'b1,1'b0,1'b0,5'd16}, '{1'b1,1'b0,1'b0,5'd12}, '{1'b1,1'b0,1'b0,5'd8},
                      '{1'b1,1'b0,1'b0,5'd4},  '{1'b0,1'b0,1'b0,5'd0},  '{1'b0,1'b0,1'b0,5'd0}};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      {IN_mispredict, IN_fuseFull, IN_fuseOutValid, IN_creditRet} = st[i];
      sb.push_back(ex[i]);
      #3;
      e = sb.pop_front();
      total++; if (OUT_fuseOutEn !== e.en) begin bad++; $display("FAIL drain[%0d] outEn got=%b want=%b", i, OUT_fuseOutEn, e.en); end
      total++; if (OUT_credits !== e.cred) begin bad++; $display("FAIL drain[%0d] credits got=%0d want=%0d", i, OUT_credits, e.cred); end
      total++; if (OUT_decStall !== e.stall) begin bad++; $display("FAIL drain[%0d] decStall got=%b want=%b", i, OUT_decStall, e.stall); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_return_clamp();
    stim_t st [6] = '{'{1'b0,1'b0,4'hF,5'd4}, '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd10},
                      '{1'b0,1'b0,4'hF,5'd15}, '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}};
    exp_t  ex [6] = '{'{1'b0,1'b0,1'b0,5'd0},  '{1'b1,1'b0,1'b0,5'd4},  '{1'b0,1'b0,1'b0,5'd0},
                      '{1'b1,1'b0,1'b0,5'd10}, '{1'b1,1'b0,1'b0,5'd16}, '{1'b1,1'b0,1'b0,5'd12}};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      {IN_mispredict, IN_fuseFull, IN_fuseOutValid, IN_creditRet} = st[i];
      sb.push_back(ex[i]);
      #3;
      e = sb.pop_front();
      total++; if (OUT_fuseOutEn !== e.en) begin bad++; $display("FAIL return[%0d] outEn got=%b want=%b", i, OUT_fuseOutEn, e.en); end
      total++; if (OUT_credits !== e.cred) begin bad++; $display("FAIL return[%0d] credits got=%0d want=%0d", i, OUT_credits, e.cred); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispredict();
    stim_t st [5] = '{'{1'b1,1'b0,4'hF,5'd5}, '{1'b0,1'b0,4'hF,5'd5}, '{1'b0,1'b0,4'hF,5'd5},
                      '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}};
    exp_t  ex [5] = '{'{1'b0,1'b1,1'b1,5'd8}, '{1'b0,1'b1,1'b1,5'd8}, '{1'b0,1'b1,1'b1,5'd8},
                      '{1'b0,1'b0,1'b1,5'd8}, '{1'b1,1'b0,1'b0,5'd16}};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      {IN_mispredict, IN_fuseFull, IN_fuseOutValid, IN_creditRet} = st[i];
      sb.push_back(ex[i]);
      #3;
      e = sb.pop_front();
      total++; if (OUT_fuseOutEn !== e.en) begin bad++; $display("FAIL mispredict[%0d] outEn got=%b want=%b", i, OUT_fuseOutEn, e.en); end
      total++; if (OUT_fuseMispredict !== e.mpo) begin bad++; $display("FAIL mispredict[%0d] fuseMispredict got=%b want=%b", i, OUT_fuseMispredict, e.mpo); end
      total++; if (OUT_decStall !== e.stall) begin bad++; $display("FAIL mispredict[%0d] decStall got=%b want=%b", i, OUT_decStall, e.stall); end
      total++; if (OUT_credits !== e.cred) begin bad++; $display("FAIL mispredict[%0d] credits got=%0d want=%0d", i, OUT_credits, e.cred); end
      @(posedge clk); #1;
    end
    total++; if (OUT_stallCnt !== 32'd4) begin bad++; $display("FAIL mispredict stallCnt got=%0d want=4", OUT_stallCnt); end
  endtask

  // Partial fuse output refunds the unused reserved slots one cycle after the debit.
  task automatic test_partial();
    stim_t st [6] = '{'{1'b0,1'b0,4'h3,5'd0}, '{1'b0,1'b0,4'h0,5'd0}, '{1'b0,1'b0,4'hF,5'd0},
                      '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}, '{1'b0,1'b1,4'hF,5'd0}};
    exp_t  ex [6] = '{'{1'b1,1'b0,1'b0,5'd12}, '{1'b1,1'b0,1'b0,5'd10}, '{1'b1,1'b0,1'b0,5'd10},
                      '{1'b1,1'b0,1'b0,5'd6},  '{1'b0,1'b0,1'b0,5'd2},  '{1'b0,1'b0,1'b1,5'd2}};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      {IN_mispredict, IN_fuseFull, IN_fuseOutValid, IN_creditRet} = st[i];
      sb.push_back(ex[i]);
      #3;
      e = sb.pop_front();
      total++; if (OUT_fuseOutEn !== e.en) begin bad++; $display("FAIL partial[%0d] outEn got=%b want=%b", i, OUT_fuseOutEn, e.en); end
      total++; if (OUT_credits !== e.cred) begin bad++; $display("FAIL partial[%0d] credits got=%0d want=%0d", i, OUT_credits, e.cred); end
      total++; if (OUT_decStall !== e.stall) begin bad++; $display("FAIL partial[%0d] decStall got=%b want=%b", i, OUT_decStall, e.stall); end
      @(posedge clk); #1;
    end
    total++; if (OUT_stallCnt !== 32'd5) begin bad++; $display("FAIL partial stallCnt got=%0d want=5", OUT_stallCnt); end
  endtask

  task automatic test_double_mispredict();
    stim_t st [7] = '{'{1'b1,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd3}, '{1'b1,1'b0,4'hF,5'd3},
                      '{1'b0,1'b0,4'hF,5'd3}, '{1'b0,1'b0,4'hF,5'd3}, '{1'b0,1'b0,4'hF,5'd0},
                      '{1'b0,1'b0,4'hF,5'd0}};
    exp_t  ex [7] = '{'{1'b0,1'b1,1'b1,5'd2}, '{1'b0,1'b1,1'b1,5'd2}, '{1'b0,1'b1,1'b1,5'd2},
                      '{1'b0,1'b1,1'b1,5'd2}, '{1'b0,1'b1,1'b1,5'd2}, '{1'b0,1'b0,1'b1,5'd2},
                      '{1'b1,1'b0,1'b0,5'd16}};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      {IN_mispredict, IN_fuseFull, IN_fuseOutValid, IN_creditRet} = st[i];
      sb.push_back(ex[i]);
      #3;
      e = sb.pop_front();
      total++; if (OUT_fuseOutEn !== e.en) begin bad++; $display("FAIL double[%0d] outEn got=%b want=%b", i, OUT_fuseOutEn, e.en); end
      total++; if (OUT_fuseMispredict !== e.mpo) begin bad++; $display("FAIL double[%0d] fuseMispredict got=%b want=%b", i, OUT_fuseMispredict, e.mpo); end
      total++; if (OUT_decStall !== e.stall) begin bad++; $display("FAIL double[%0d] decStall got=%b want=%b", i, OUT_decStall, e.stall); end
      total++; if (OUT_credits !== e.cred) begin bad++; $display("FAIL double[%0d] credits got=%0d want=%0d", i, OUT_credits, e.cred); end
      @(posedge clk); #1;
    end
    total++; if (OUT_stallCnt !== 32'd11) begin bad++; $display("FAIL double stallCnt got=%0d want=11", OUT_stallCnt); end
  endtask

  task automatic test_async_reset();
    stim_t st [2] = '{'{1'b1,1'b0,4'hF,5'd0}, '{1'b0,1'b0,4'hF,5'd0}};
    exp_t  ex [2] = '{'{1'b0,1'b1,1'b1,5'd12}, '{1'b0,1'b1,1'b1,5'd12}};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      {IN_mispredict, IN_fuseFull, IN_fuseOutValid, IN_creditRet} = st[i];
      sb.push_back(ex[i]);
      #3;
      e = sb.pop_front();
      total++; if (OUT_fuseMispredict !== e.mpo) begin bad++; $display("FAIL async[%0d] fuseMispredict got=%b want=%b", i, OUT_fuseMispredict, e.mpo); end
      total++; if (OUT_credits !== e.cred) begin bad++; $display("FAIL async[%0d] credits got=%0d want=%0d", i, OUT_credits, e.cred); end
      @(posedge clk); #1;
    end
    // Still in FLUSH here; pull reset between clock edges.
    #2 rst = 1'b0;
    #1;
    total++; if (OUT_fuseOutEn !== 1'b1) begin bad++; $display("FAIL async outEn got=%b want=1", OUT_fuseOutEn); end
    total++; if (OUT_fuseMispredict !== 1'b0) begin bad++; $display("FAIL async fuseMispredict got=%b want=0", OUT_fuseMispredict); end
    total++; if (OUT_decStall !== 1'b0) begin bad++; $display("FAIL async decStall got=%b want=0", OUT_decStall); end
    total++; if (OUT_credits !== 5'd16) begin bad++; $display("FAIL async credits got=%0d want=16", OUT_credits); end
    total++; if (OUT_stallCnt !== 32'd0) begin bad++; $display("FAIL async stallCnt got=%0d want=0", OUT_stallCnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    total++; if (OUT_fuseOutEn !== 1'b1) begin bad++; $display("FAIL post-reset outEn got=%b want=1", OUT_fuseOutEn); end
    total++; if (OUT_credits !== 5'd16) begin bad++; $display("FAIL post-reset credits got=%0d want=16", OUT_credits); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_return_clamp();
    test_mispredict();
    test_partial();
    test_double_mispredict();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
